// File: rtl/prbs_pkg.sv
// prbs_pkg -- definitions shared by the PRBS generator and checker.
//   state_e  : checker state machine encoding (FILL, HUNT, LOCK)
//   DEF_W    : default LFSR degree
//   DEF_POLY : default feedback polynomial (W+1 bits, bit W and bit 0 set)
package prbs_pkg;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HUNT = 2'd1,
      LOCK = 2'd2
   } state_e;

   localparam int         DEF_W    = 8;
   localparam logic [8:0] DEF_POLY = 9'h11D;

endpackage

// File: rtl/prbs_err_window.sv
// prbs_err_window -- error-density window used for loss-of-lock detection.
// Counts en-qualified bits in fixed windows of WIN bits and the errors within
// the current window. loss is asserted combinationally on the step that
// brings the window error count up to LOSS_THR.
// Ports:
//   clk, arst : clock, synchronous active-high reset
//   step      : one checked bit this cycle (en while locked)
//   error     : that bit was mismatched
//   restart   : hold the window cleared (checker not locked)
//   loss      : this step trips the loss threshold
module prbs_err_window #(
   parameter int WIN      = 64,
   parameter int LOSS_THR = 8
) (
   input  logic clk,
   input  logic arst,
   input  logic step,
   input  logic error,
   input  logic restart,
   output logic loss
);

   localparam int WC_W = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int WE_W = $clog2(LOSS_THR + 1);

   logic [WC_W-1:0] win_cnt;
   logic [WE_W-1:0] win_err;

   assign loss = step && error && (win_err == WE_W'(LOSS_THR - 1));

   always_ff @(posedge clk) begin
      if (arst || restart) begin
         win_cnt <= '0;
         win_err <= '0;
      end else if (step) begin
         // Loss takes priority over the window rollover; both clear the window.
         if (loss || (win_cnt == WC_W'(WIN - 1))) begin
            win_cnt <= '0;
            win_err <= '0;
         end else begin
            win_cnt <= win_cnt + WC_W'(1);
            if (error && (win_err != WE_W'(LOSS_THR)))
               win_err <= win_err + WE_W'(1);
         end
      end
   end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker -- self-synchronising serial PRBS checker.
// Fills a W-bit history, hunts for LOCK_CNT consecutive correct predictions,
// then free-runs its predictor so each corrupted bit is flagged exactly once.
// Too many errors within one WIN-bit window drops lock and restarts the fill.
// Optional macro PRBS_CHK_CNT_EN: implements err_cnt/bit_cnt; when undefined
// both counters read 0 and clr is ignored.
// Ports:
//   clk, arst : clock, synchronous active-high reset
//   en        : in is valid this cycle; all state advances only when set
//   in        : received PRBS bit
//   clr       : synchronous clear of err_cnt and bit_cnt
//   locked    : checker is in LOCK
//   err       : one-cycle pulse for a mismatched bit while locked
//   err_cnt   : saturating count of errored bits
//   bit_cnt   : saturating count of bits checked while locked
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int         W        = DEF_W,
   parameter logic [W:0] POLY     = DEF_POLY,
   parameter int         LOCK_CNT = 16,
   parameter int         WIN      = 64,
   parameter int         LOSS_THR = 8,
   parameter int         CNT_W    = 32
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             en,
   input  logic             in,
   input  logic             clr,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam int FC_W = $clog2(W + 1);
   localparam int MC_W = $clog2(LOCK_CNT + 1);

   state_e          state, state_nxt;
   logic [W-1:0]    h;
   logic [FC_W-1:0] fill_cnt;
   logic [MC_W-1:0] match_cnt;
   logic            pred, mism, match, step, loss;

   // Generator output recurrence over the history (h[0] newest).
   always_comb begin
      pred = 1'b0;
      for (int k = 1; k <= W; k++)
         pred = pred ^ (POLY[k] & h[k-1]);
   end

   assign mism  = in ^ pred;
   // An all-zero history predicts 0 forever, so it must never count as a match.
   assign match = !mism && (h != '0);
   assign step  = en && (state == LOCK);

   prbs_err_window #(
      .WIN      (WIN),
      .LOSS_THR (LOSS_THR)
   ) u_win (
      .clk     (clk),
      .arst    (arst),
      .step    (step),
      .error   (mism),
      .restart (state != LOCK),
      .loss    (loss)
   );

   always_comb begin
      state_nxt = state;
      if (en) begin
         case (state)
            FILL:    if (fill_cnt == FC_W'(W - 1)) state_nxt = HUNT;
            HUNT:    if (match && (match_cnt == MC_W'(LOCK_CNT - 1))) state_nxt = LOCK;
            LOCK:    if (loss) state_nxt = FILL;
            default: state_nxt = FILL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state     <= FILL;
         h         <= '0;
         fill_cnt  <= '0;
         match_cnt <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
      end else begin
         locked <= (state_nxt == LOCK);
         err    <= step && mism;
         if (en) begin
            state <= state_nxt;
            case (state)
               FILL: begin
                  h <= {h[W-2:0], in};
                  if (fill_cnt == FC_W'(W - 1)) begin
                     fill_cnt  <= '0;
                     match_cnt <= '0;
                  end else begin
                     fill_cnt <= fill_cnt + FC_W'(1);
                  end
               end
               HUNT: begin
                  h         <= {h[W-2:0], in};
                  match_cnt <= match ? match_cnt + MC_W'(1) : '0;
               end
               LOCK: begin
                  if (loss) begin
                     h         <= '0;
                     fill_cnt  <= '0;
                     match_cnt <= '0;
                  end else begin
                     // Free-run: feed back our own prediction, not the line.
                     h <= {h[W-2:0], pred};
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef PRBS_CHK_CNT_EN
   always_ff @(posedge clk) begin
      if (arst || clr) begin
         err_cnt <= '0;
         bit_cnt <= '0;
      end else begin
         if (step && mism && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
         if (step && (bit_cnt != '1))         bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end
`else
   logic unused_clr;
   assign unused_clr = clr;
   assign err_cnt    = '0;
   assign bit_cnt    = '0;
`endif

endmodule
